// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU memory stage and an external loader/debug port
// share one single-port synchronous memory. Each access takes a fixed
// IDLE -> ISSUE -> DATA sequence. The CPU has priority, but a starvation
// counter lets a waiting external requester through after STARVE_LIM
// consecutive CPU grants.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [3:0]        ext_be,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              cpu_ack,
    output logic              ext_ack,
    output logic [31:0]       cpu_rdata,
    output logic [31:0]       ext_rdata,
    output logic              hold,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                sel_ext_reg;
    logic                cmd_we_reg;
    logic [3:0]          cmd_be_reg;
    logic [ADDR_W-3:0]   cmd_addr_reg;
    logic [31:0]         cmd_wdata_reg;
    logic [CNT_W-1:0]    starve_cnt_reg;
    logic [31:0]         cpu_rdata_reg;
    logic [31:0]         ext_rdata_reg;
    logic                grant;
    logic                grant_ext;

    // Byte-offset bits are deliberately dropped: requesters align their own accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[1:0], ext_addr[1:0]};

    // Next-state, arbitration decision and memory/ack decode from the current state.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        grant_ext  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        cpu_ack    = 1'b0;
        ext_ack    = 1'b0;
        case (state_reg)
            IDLE: begin
                grant     = cpu_req | ext_req;
                grant_ext = ext_req & (~cpu_req | (starve_cnt_reg == CNT_MAX));
                if (grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = cmd_we_reg ? cmd_be_reg : 4'b0000;
                state_next = DATA;
            end
            DATA: begin
                cpu_ack    = ~sel_ext_reg;
                ext_ack    = sel_ext_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the winner's command when a grant is made in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_ext_reg   <= 1'b0;
            cmd_we_reg    <= 1'b0;
            cmd_be_reg    <= 4'b0000;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= 32'h0;
        end else if (grant) begin
            sel_ext_reg   <= grant_ext;
            cmd_we_reg    <= grant_ext ? ext_we : cpu_we;
            cmd_be_reg    <= grant_ext ? ext_be : cpu_be;
            cmd_addr_reg  <= grant_ext ? ext_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
            cmd_wdata_reg <= grant_ext ? ext_wdata : cpu_wdata;
        end
    end

    // Count CPU grants that overtook a waiting ext request; clear when ext is served or absent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (grant_ext || !ext_req) begin
                starve_cnt_reg <= '0;
            end else if (grant && (starve_cnt_reg != CNT_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Keep the last word returned to each requester; only the winner's copy changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_reg <= 32'h0;
            ext_rdata_reg <= 32'h0;
        end else if (state_reg == DATA) begin
            if (sel_ext_reg) begin
                ext_rdata_reg <= mem_rdata;
            end else begin
                cpu_rdata_reg <= mem_rdata;
            end
        end
    end

    // The memory word arrives in the ack cycle itself, so it is forwarded then
    // and held from the register afterwards.
    assign cpu_rdata = cpu_ack ? mem_rdata : cpu_rdata_reg;
    assign ext_rdata = ext_ack ? mem_rdata : ext_rdata_reg;

    assign mem_addr  = cmd_addr_reg;
    assign mem_wdata = cmd_wdata_reg;

    // The pipeline advances exactly in the cycle its access is acknowledged.
    assign hold = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two random requesters, a read-first
// synchronous memory, and a transaction-level reference that schedules each
// granted access at fixed offsets and tracks expected memory contents.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int STARVE_LIM = 4;
    localparam int NCYC       = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, ext_req, ext_we;
    logic [3:0]        cpu_be, ext_be;
    logic [ADDR_W-1:0] cpu_addr, ext_addr;
    logic [31:0]       cpu_wdata, ext_wdata;
    logic              cpu_ack, ext_ack, hold, mem_en;
    logic [31:0]       cpu_rdata, ext_rdata, mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .cpu_ack(cpu_ack), .ext_ack(ext_ack), .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata),
        .hold(hold), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Read-first single-port memory, 64 words, indexed by the low word-address bits.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[5:0]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    // Reference state
    logic [31:0]       ref_mem [0:63];
    int                cyc, free_at, issue_at, ack_at, starve;
    bit                win_ext;
    logic              p_we;
    logic [3:0]        p_be;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0]       p_wdata, ack_data, exp_cpu_rdata, exp_ext_rdata;
    bit                last_cpu_ack, last_ext_ack;
    int                rst_left;
    bit                rst_issue_done, rst_data_done;
    int                vectors, miscompares;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Advance the reference across one rising edge, using the inputs of the closing cycle.
    task automatic model_step();
        int  idx;
        bit  take_ext;
        if (!rst) begin
            starve  = 0;
            free_at = cyc + 1;
        end else begin
            if (cyc == issue_at) begin
                idx      = int'(p_addr[7:2]);
                ack_data = ref_mem[idx];
                if (p_we) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[b]) ref_mem[idx][b*8 +: 8] = p_wdata[b*8 +: 8];
                end
            end
            if (cyc == ack_at) begin
                if (win_ext) exp_ext_rdata = ack_data;
                else         exp_cpu_rdata = ack_data;
            end
            if (cyc >= free_at) begin
                if (!ext_req) starve = 0;
                if (cpu_req || ext_req) begin
                    take_ext = ext_req && (!cpu_req || starve == STARVE_LIM);
                    win_ext  = take_ext;
                    if (take_ext) begin
                        p_we = ext_we; p_be = ext_be; p_addr = ext_addr; p_wdata = ext_wdata;
                        starve = 0;
                    end else begin
                        p_we = cpu_we; p_be = cpu_be; p_addr = cpu_addr; p_wdata = cpu_wdata;
                        if (ext_req) starve = (starve + 1 > STARVE_LIM) ? STARVE_LIM : starve + 1;
                    end
                    issue_at = cyc + 1;
                    ack_at   = cyc + 2;
                    free_at  = cyc + 3;
                end
            end
        end
        cyc++;
    endtask

    // Reset asserted at the start of cycle cyc: drop anything not yet written.
    task automatic model_reset();
        if (issue_at >= cyc) issue_at = -1;
        ack_at        = -1;
        starve        = 0;
        exp_cpu_rdata = 32'h0;
        exp_ext_rdata = 32'h0;
    endtask

    task automatic drive_inputs();
        int rate, drop;
        if (rst_left == 0 && !rst_issue_done && cyc > 800 && issue_at == cyc) begin
            rst_left = 2; rst_issue_done = 1;
        end
        if (rst_left == 0 && !rst_data_done && cyc > 2200 && ack_at == cyc) begin
            rst_left = 2; rst_data_done = 1;
        end
        if (rst_left == 0 && cyc == 1300) rst_left = 3;
        if (rst_left > 0) begin
            rst = 1'b0;
            model_reset();
            rst_left--;
        end else begin
            rst = 1'b1;
        end
        rate = (cyc < 1000) ? 40 : (cyc < 2000) ? 100 : 60;
        drop = (cyc >= 1000 && cyc < 2000) ? 0 : 4;
        if (!cpu_req || last_cpu_ack) begin
            cpu_req = ($urandom_range(99) < rate);
            cpu_we = 1'($urandom_range(1)); cpu_be = 4'($urandom_range(15));
            cpu_addr = $urandom(); cpu_wdata = $urandom();
        end else if ($urandom_range(99) < drop) begin
            cpu_req = 1'b0;
        end
        if (!ext_req || last_ext_ack) begin
            ext_req = ($urandom_range(99) < rate);
            ext_we = 1'($urandom_range(1)); ext_be = 4'($urandom_range(15));
            ext_addr = $urandom(); ext_wdata = $urandom();
        end else if ($urandom_range(99) < drop) begin
            ext_req = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit en_exp, cack_exp, eack_exp;
        en_exp   = rst && (cyc == issue_at);
        cack_exp = rst && (cyc == ack_at) && !win_ext;
        eack_exp = rst && (cyc == ack_at) && win_ext;
        check_val("mem_en", 32'(mem_en), 32'(en_exp));
        check_val("mem_we", 32'(mem_we), (en_exp && p_we) ? 32'(p_be) : 32'h0);
        if (en_exp) begin
            check_val("mem_addr", 32'(mem_addr), 32'(p_addr[ADDR_W-1:2]));
            check_val("mem_wdata", mem_wdata, p_wdata);
        end
        if (!rst) begin
            check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
            check_val("rst_mem_wdata", mem_wdata, 32'h0);
        end
        check_val("cpu_ack", 32'(cpu_ack), 32'(cack_exp));
        check_val("ext_ack", 32'(ext_ack), 32'(eack_exp));
        check_val("cpu_rdata", cpu_rdata, cack_exp ? ack_data : exp_cpu_rdata);
        check_val("ext_rdata", ext_rdata, eack_exp ? ack_data : exp_ext_rdata);
        check_val("hold", 32'(hold), 32'(cpu_req && !cack_exp));
        last_cpu_ack = cack_exp;
        last_ext_ack = eack_exp;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = 32'h0;
        ext_req = 1'b0; ext_we = 1'b0; ext_be = 4'h0; ext_addr = '0; ext_wdata = 32'h0;
        cyc = 0; free_at = 0; issue_at = -1; ack_at = -1; starve = 0; win_ext = 0;
        p_we = 0; p_be = 4'h0; p_addr = '0; p_wdata = 32'h0; ack_data = 32'h0;
        exp_cpu_rdata = 32'h0; exp_ext_rdata = 32'h0;
        last_cpu_ack = 0; last_ext_ack = 0;
        rst_left = 3; rst_issue_done = 0; rst_data_done = 0;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            model_step();
            #1;
            drive_inputs();
            @(negedge clk);
            check_outputs();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
